cpu_rng_pacer: RTL and testbench
================================

Name: cpu_rng_pacer

Overview:
- Upstream stage of the computer-player path in the tug-of-war design.
- Produces the 10-bit pseudo-random value `comp` that the press comparator checks against the difficulty switches.
- A 10-bit maximal-length LFSR is advanced once every DIV enabled clocks, so the computer's press attempts are paced.
- Adds seed load, lockup protection, a game-over halt, and a one-cycle update strobe.

Parameters:
- DIV, 8, number of enabled clk cycles per LFSR step; legal range 1..1023.
- SEED, 10'h001, LFSR value at reset; must be nonzero.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; the pacing counter advances only while high.
- freeze  input  1  game-over halt request; sampled each cycle.
- load  input  1  seed load strobe; highest priority after reset.
- seed  input  10  value loaded when load=1.
- comp  output  10  current LFSR state; registered, driven straight from the state flop.
- valid  output  1  high for exactly the cycle in which comp first shows a new value.
- seed_fix  output  1  sticky flag: the last load carried seed==0 and 10'h001 was substituted.
- wrap  output  1  one-cycle pulse when a step returns comp to the last loaded/reset value (full 1023-step period).

Behaviour:
- Reset (asynchronous, any time, including mid-count or in HALT):
  - comp=SEED, counter=0, valid=0, seed_fix=0, wrap=0, state=IDLE.
  - Origin register = SEED.
- LFSR is Fibonacci with taps at bits 10 and 7:
  - fb = comp[9] ^ comp[6].
  - next = {comp[8:0], fb}.
  - Period 1023; 10'h000 is never produced from a nonzero state.
- Pacing counter:
  - 10 bits, counts 0..DIV-1.
  - A "step" occurs at the rising edge where the state is RUN, en=1 and counter==DIV-1.
  - On that edge: comp<=next, counter<=0.
  - DIV=1 gives one step per enabled clock.
- FSM states are IDLE, RUN and HALT.
  - IDLE: counter is held (not cleared). Go to RUN when en=1 and freeze=0; the counter begins incrementing on that same edge.
  - RUN: the counter increments while en=1.
    - en=0 → go to IDLE, counter held, so pacing resumes where it stopped.
    - freeze=1 → go to HALT.
  - HALT: comp and counter frozen; en is ignored. Leave only via load or reset. A load goes to IDLE.
  - freeze and step on the same edge: freeze wins; no step, go to HALT.
- Load (priority below reset only, effective in every state):
  - comp<=seed, or 10'h001 if seed==0.
  - Origin<=the loaded value; counter<=0; valid<=1.
  - seed_fix<=(seed==0). It stays at that value until the next load or reset.
  - Load overrides a coincident step or freeze.
- valid:
  - Registered.
  - High in the cycle after a step edge or a load edge; low otherwise.
  - Back-to-back steps (DIV=1) keep valid continuously high.
- wrap:
  - Registered; asserted together with valid when a step's next value equals origin.
  - Never asserted on a load.
- Steps use the unsigned 10-bit state only. No other arithmetic; the counter compare is unsigned.

Test Plan:
- Reset value: assert reset with DIV=8, SEED=1 → comp=10'h001, valid=0, seed_fix=0, wrap=0. Deasserting reset with en=0 keeps comp at 10'h001 indefinitely.
- Sequence and pacing: DIV=1, en=1 from reset.
  - comp steps 001,002,004,008,010,020,040,081,102,204,009 on consecutive cycles, with valid continuously high.
  - With DIV=8, the same sequence appears with valid pulsing one cycle every 8 clocks.
- Enable gating: DIV=8, drop en after 5 counts and hold low for 20 cycles, then raise it → the next step occurs exactly 3 enabled cycles after en returns; comp is unchanged while en=0.
- Seed load and lockup:
  - load=1, seed=10'h2A5 → comp=2A5, valid pulse, seed_fix=0, counter cleared.
  - load=1, seed=0 → comp=001, seed_fix=1. seed_fix stays high through stepping until the next load with nonzero seed.
- Freeze:
  - freeze=1 in RUN → comp holds; en toggling has no effect for 50 cycles.
  - freeze coincident with a step edge → no step.
  - A subsequent load=1, seed=10'h155 → comp=155, state IDLE, then RUN when en=1, freeze=0.
- Period and async reset:
  - DIV=1 from SEED=1 → wrap pulses exactly once, on the 1023rd step (comp=001). No zero state is ever seen.
  - Asserting reset between clock edges mid-run → comp=001 and valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_rng_pacer.sv
// Paced 10-bit Fibonacci LFSR (x^10 + x^7 + 1) feeding the computer-player press comparator.
// Steps once every DIV enabled clocks, with seed load, zero-seed substitution and a game-over halt.
module cpu_rng_pacer #(
    parameter int unsigned DIV  = 8,
    parameter logic [9:0]  SEED = 10'h001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       freeze,
    input  logic       load,
    input  logic [9:0] seed,
    output logic [9:0] comp,
    output logic       valid,
    output logic       seed_fix,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [9:0] LAST = 10'(DIV - 1);

    state_t     state_reg;
    logic [9:0] cnt_reg;
    logic [9:0] origin_reg;
    logic [9:0] lfsr_next;
    logic [9:0] seed_eff;

    assign lfsr_next = {comp[8:0], comp[9] ^ comp[6]};
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_eff  = (seed == 10'h000) ? 10'h001 : seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 10'h000;
            origin_reg <= SEED;
            comp       <= SEED;
            valid      <= 1'b0;
            seed_fix   <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
            if (load) begin
                comp       <= seed_eff;
                origin_reg <= seed_eff;
                cnt_reg    <= 10'h000;
                valid      <= 1'b1;
                seed_fix   <= (seed == 10'h000);
                state_reg  <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (freeze) begin
                            state_reg <= HALT;
                        end else if (en) begin
                            state_reg <= RUN;
                            // Counter is held in IDLE; the RUN entry edge already counts.
                            if (cnt_reg != LAST)
                                cnt_reg <= cnt_reg + 10'd1;
                        end
                    end
                    RUN: begin
                        if (freeze) begin
                            state_reg <= HALT;
                        end else if (!en) begin
                            state_reg <= IDLE;
                        end else if (cnt_reg == LAST) begin
                            comp    <= lfsr_next;
                            cnt_reg <= 10'h000;
                            valid   <= 1'b1;
                            wrap    <= (lfsr_next == origin_reg);
                        end else begin
                            cnt_reg <= cnt_reg + 10'd1;
                        end
                    end
                    HALT: begin
                        state_reg <= HALT;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_rng_pacer.sv
// Directed bench for cpu_rng_pacer: one DIV=1 and one DIV=8 instance share the stimulus.
module tb_cpu_rng_pacer;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       en     = 1'b0;
    logic       freeze = 1'b0;
    logic       load   = 1'b0;
    logic [9:0] seed   = 10'h000;

    logic [9:0] comp1, comp8;
    logic       valid1, valid8, seed_fix1, seed_fix8, wrap1, wrap8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] seq1 [0:9] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                               10'h040, 10'h081, 10'h102, 10'h204, 10'h009};

    cpu_rng_pacer #(.DIV(1), .SEED(10'h001)) u1 (
        .clk(clk), .reset(reset), .en(en), .freeze(freeze), .load(load), .seed(seed),
        .comp(comp1), .valid(valid1), .seed_fix(seed_fix1), .wrap(wrap1)
    );

    cpu_rng_pacer #(.DIV(8), .SEED(10'h001)) u8 (
        .clk(clk), .reset(reset), .en(en), .freeze(freeze), .load(load), .seed(seed),
        .comp(comp8), .valid(valid8), .seed_fix(seed_fix8), .wrap(wrap8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  wraps;
        int  wrap_at;
        bit  zero_seen;
        bit  valid_drop;

        // Reset values
        tick();
        tick();
        check("rst_comp1", comp1, 10'h001);
        check("rst_valid1", valid1, 0);
        check("rst_fix1", seed_fix1, 0);
        check("rst_wrap1", wrap1, 0);
        check("rst_comp8", comp8, 10'h001);
        check("rst_valid8", valid8, 0);
        check("rst_fix8", seed_fix8, 0);
        check("rst_wrap8", wrap8, 0);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_hold_comp", comp8, 10'h001);
        check("idle_hold_valid", valid8, 0);

        // DIV=1 sequence: first enabled edge only enters RUN
        en = 1'b1;
        tick();
        check("div1_entry_valid", valid1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("div1_seq", comp1, seq1[i]);
            check("div1_valid", valid1, 1);
        end

        // DIV=8 pacing: valid once every 8 enabled clocks
        en = 1'b0;
        do_reset();
        en = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            check("div8_valid", valid8, (t % 8 == 0) ? 1 : 0);
            if (t % 8 == 0)
                check("div8_seq", comp8, seq1[t / 8 - 1]);
        end

        // Enable gating: 5 counts, 20 idle cycles, step 3 enabled cycles later
        en = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("gate_comp", comp8, 10'h001);
            check("gate_valid", valid8, 0);
        end
        en = 1'b1;
        tick();
        check("gate_resume1", valid8, 0);
        tick();
        check("gate_resume2", valid8, 0);
        tick();
        check("gate_step_valid", valid8, 1);
        check("gate_step_comp", comp8, 10'h002);

        // Load mid-count clears the counter
        repeat (3) tick();
        load = 1'b1;
        seed = 10'h2A5;
        tick();
        load = 1'b0;
        check("load_comp", comp8, 10'h2A5);
        check("load_valid", valid8, 1);
        check("load_fix", seed_fix8, 0);
        check("load_wrap", wrap8, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("load_pace_valid", valid8, 0);
        end
        check("load_pace_comp", comp8, 10'h2A5);
        tick();
        check("load_step_valid", valid8, 1);
        check("load_step_comp", comp8, 10'h14B);

        // Zero seed substitution and sticky seed_fix
        load = 1'b1;
        seed = 10'h000;
        tick();
        load = 1'b0;
        check("zseed_comp", comp8, 10'h001);
        check("zseed_fix", seed_fix8, 1);
        check("zseed_valid", valid8, 1);
        repeat (8) tick();
        check("zseed_step_comp", comp8, 10'h002);
        check("zseed_step_valid", valid8, 1);
        check("zseed_fix_sticky", seed_fix8, 1);
        load = 1'b1;
        seed = 10'h003;
        tick();
        load = 1'b0;
        check("nzseed_comp", comp8, 10'h003);
        check("nzseed_fix", seed_fix8, 0);

        // Freeze in RUN: en toggling has no effect
        tick();
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        check("freeze_comp", comp8, 10'h003);
        check("freeze_valid", valid8, 0);
        for (int i = 0; i < 50; i++) begin
            en = i[0];
            tick();
            check("halt_comp", comp8, 10'h003);
            check("halt_valid", valid8, 0);
        end

        // Load leaves HALT, then RUN resumes stepping
        en = 1'b0;
        load = 1'b1;
        seed = 10'h155;
        tick();
        load = 1'b0;
        check("halt_load_comp", comp8, 10'h155);
        check("halt_load_valid", valid8, 1);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("relaunch_valid", valid8, 0);
        end
        tick();
        check("relaunch_step_comp", comp8, 10'h2AB);
        check("relaunch_step_valid", valid8, 1);

        // Freeze on the step edge wins
        repeat (7) tick();
        check("pre_freeze_valid", valid8, 0);
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        check("freeze_step_comp", comp8, 10'h2AB);
        check("freeze_step_valid", valid8, 0);
        repeat (10) tick();
        check("freeze_step_hold", comp8, 10'h2AB);

        // Asynchronous reset between edges
        load = 1'b1;
        seed = 10'h001;
        tick();
        load = 1'b0;
        tick();
        tick();
        check("pre_areset_comp", comp1, 10'h002);
        check("pre_areset_valid", valid1, 1);
        #3;
        reset = 1'b1;
        #1;
        check("areset_comp1", comp1, 10'h001);
        check("areset_valid1", valid1, 0);
        check("areset_comp8", comp8, 10'h001);
        tick();
        reset = 1'b0;

        // Full period on DIV=1
        en = 1'b1;
        tick();
        wraps      = 0;
        wrap_at    = 0;
        zero_seen  = 1'b0;
        valid_drop = 1'b0;
        for (int s = 1; s <= 1023; s++) begin
            tick();
            if (comp1 == 10'h000) zero_seen = 1'b1;
            if (!valid1) valid_drop = 1'b1;
            if (wrap1) begin
                wraps++;
                wrap_at = s;
            end
        end
        check("period_wraps", wraps, 1);
        check("period_wrap_at", wrap_at, 1023);
        check("period_end_comp", comp1, 10'h001);
        check("period_no_zero", zero_seen, 0);
        check("period_valid_high", valid_drop, 0);
        tick();
        check("post_wrap_pulse", wrap1, 0);
        check("post_wrap_comp", comp1, 10'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
